rbuf_addr_gen_mc: RTL and testbench

Multi-channel ring-buffer address generator for the sample-rate-converter controller. It keeps one circular sample region per channel in shared data RAM. It issues the write address for each incoming sample and advances that channel's head. On request it walks a programmed number of taps backwards from the newest sample, wrapping inside the region, to feed the FIR MAC datapath. It replaces the single-channel head/tail counter with per-channel state, explicit length control, a completion handshake and error reporting.

---
 rtl/rbuf_pkg.sv | 41 ++++
 rtl/rbuf_wrap_step.sv | 24 ++
 rtl/rbuf_addr_gen_mc.sv | 178 +++++++++++++++++
 tb/tb_rbuf_addr_gen_mc.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbuf_pkg.sv
// Shared types, default widths and the ring wrap helper for the ring-buffer address generator.
// Latency: none; declarations and a pure combinational function only.
// Backpressure: not applicable.
package rbuf_pkg;

  // Walk controller states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WALK = 2'b01,
    FIN  = 2'b10
  } rbuf_state_t;

  // Default geometry
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_OFF_W    = 10;
  localparam int DEF_CHANNELS = 4;

  // Working width of the wrap helper; callers zero-extend into it (address widths below 32)
  localparam int WRAP_MAX_W = 32;

  // Step direction for the wrap helper
  localparam logic DIR_DN = 1'b0;
  localparam logic DIR_UP = 1'b1;

  // Next pointer inside the inclusive region [lo, hi], wrapping at either end
  function automatic logic [WRAP_MAX_W-1:0] wrap_step(
    input logic [WRAP_MAX_W-1:0] ptr,
    input logic [WRAP_MAX_W-1:0] lo,
    input logic [WRAP_MAX_W-1:0] hi,
    input logic                  dir
  );
    logic [WRAP_MAX_W-1:0] nxt;
    if (dir == DIR_UP) begin
      nxt = (ptr == hi) ? lo : ptr + 1'b1;
    end else begin
      nxt = (ptr == lo) ? hi : ptr - 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rbuf_wrap_step.sv
// Purpose: one wrapped step of a ring pointer inside an inclusive [lo, hi] region, up or down.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module rbuf_wrap_step
  import rbuf_pkg::*;
#(
  parameter int A = DEF_ADDR_W
) (
  input  logic [A-1:0] ptr,
  input  logic [A-1:0] lo,
  input  logic [A-1:0] hi,
  input  logic         dir,
  output logic [A-1:0] nxt
);

  logic [WRAP_MAX_W-1:0] full;
  logic                  unused_hi;

  // Shared helper works at a fixed wide width; only the low A bits matter
  assign full      = wrap_step(WRAP_MAX_W'(ptr), WRAP_MAX_W'(lo), WRAP_MAX_W'(hi), dir);
  assign nxt       = full[A-1:0];
  assign unused_hi = |full[WRAP_MAX_W-1:A];

endmodule

// File: rtl/rbuf_addr_gen_mc.sv
// Purpose: per-channel ring-buffer write heads plus a backward tap walker for the FIR MAC; optional command checks under RBUF_ERR_CHECK_EN.
// Latency: wr_addr combinational; rd_addr/rd_valid one edge after rd_start, one edge per rd_step, rd_done one cycle after the final step.
// Backpressure: rd_step paces the walk; rd_start outside IDLE is ignored (err pulse when RBUF_ERR_CHECK_EN is defined).
module rbuf_addr_gen_mc
  import rbuf_pkg::*;
#(
  parameter int DATA_ADDRESS_WIDTH = DEF_ADDR_W,
  parameter int DATA_OFFSET_WIDTH  = DEF_OFF_W,
  parameter int CHANNELS           = DEF_CHANNELS,
  parameter int CH_WIDTH           = $clog2(CHANNELS)
) (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          cfg_we,
  input  logic [CH_WIDTH-1:0]           cfg_ch,
  input  logic [DATA_ADDRESS_WIDTH-1:0] cfg_lo,
  input  logic [DATA_ADDRESS_WIDTH-1:0] cfg_hi,
  input  logic                          wr_en,
  input  logic [CH_WIDTH-1:0]           wr_ch,
  output logic [DATA_ADDRESS_WIDTH-1:0] wr_addr,
  input  logic                          rd_start,
  input  logic [CH_WIDTH-1:0]           rd_ch,
  input  logic [DATA_OFFSET_WIDTH-1:0]  rd_len,
  input  logic                          rd_step,
  output logic [DATA_ADDRESS_WIDTH-1:0] rd_addr,
  output logic                          rd_valid,
  output logic                          rd_last,
  output logic                          rd_done,
  output logic                          busy,
  output logic                          err
);

  localparam int A = DATA_ADDRESS_WIDTH;
  localparam int L = DATA_OFFSET_WIDTH;

  // Per-channel region bounds and write head
  logic [A-1:0] lo_q   [CHANNELS];
  logic [A-1:0] hi_q   [CHANNELS];
  logic [A-1:0] head_q [CHANNELS];

  // Walk state: latched bounds, current tap, taps left including the current one
  rbuf_state_t  state_q, state_d;
  logic [A-1:0] lat_lo_q, lat_hi_q, addr_q;
  logic [L-1:0] remain_q;

  logic [A-1:0] head_nxt;
  logic [A-1:0] rs_ptr, rs_lo, rs_hi, rd_nxt;
  logic         start_acc, cfg_acc;

  assign wr_addr = head_q[wr_ch];

  // Write head advance for the channel being written
  rbuf_wrap_step #(.A(A)) u_wr_step (
    .ptr (head_q[wr_ch]),
    .lo  (lo_q[wr_ch]),
    .hi  (hi_q[wr_ch]),
    .dir (DIR_UP),
    .nxt (head_nxt)
  );

  // Read stepper source: from the live head when starting, from the current tap while walking
  always_comb begin
    rs_ptr = addr_q;
    rs_lo  = lat_lo_q;
    rs_hi  = lat_hi_q;
    if (state_q == IDLE) begin
      rs_ptr = head_q[rd_ch];
      rs_lo  = lo_q[rd_ch];
      rs_hi  = hi_q[rd_ch];
    end
  end

  rbuf_wrap_step #(.A(A)) u_rd_step (
    .ptr (rs_ptr),
    .lo  (rs_lo),
    .hi  (rs_hi),
    .dir (DIR_DN),
    .nxt (rd_nxt)
  );

`ifdef RBUF_ERR_CHECK_EN
  logic [CH_WIDTH-1:0] lat_ch_q;
  logic [A:0]          rd_size, len_ext;
  logic                len_bad, cfg_bad, err_d, err_q;

  // Command screening: length against region size, bounds order, reconfiguring the walked channel
  always_comb begin
    rd_size   = {1'b0, hi_q[rd_ch]} - {1'b0, lo_q[rd_ch]} + 1'b1;
    len_ext   = (A+1)'(rd_len);
    len_bad   = (rd_len == '0) || (len_ext > rd_size);
    cfg_bad   = (cfg_lo > cfg_hi) || ((state_q != IDLE) && (cfg_ch == lat_ch_q));
    start_acc = rd_start && (state_q == IDLE) && !len_bad;
    cfg_acc   = cfg_we && !cfg_bad;
    err_d     = (rd_start && ((state_q != IDLE) || len_bad)) || (cfg_we && cfg_bad);
  end

  // Error pulse register and walked-channel latch
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      err_q    <= 1'b0;
      lat_ch_q <= '0;
    end else begin
      err_q <= err_d;
      if (start_acc) lat_ch_q <= rd_ch;
    end
  end

  assign err = err_q;
`else
  // Unchecked build: zero length counts down through 2^L, long walks keep wrapping
  assign start_acc = rd_start && (state_q == IDLE);
  assign cfg_acc   = cfg_we;
  assign err       = 1'b0;
`endif

  // Region table: configuration takes precedence over a same-cycle write on that channel
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        lo_q[c]   <= '0;
        hi_q[c]   <= '0;
        head_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_acc && (cfg_ch == CH_WIDTH'(c))) begin
          lo_q[c]   <= cfg_lo;
          hi_q[c]   <= cfg_hi;
          head_q[c] <= cfg_lo;
        end else if (wr_en && (wr_ch == CH_WIDTH'(c))) begin
          head_q[c] <= head_nxt;
        end
      end
    end
  end

  // Walk state register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Walk next-state: start, step to the final tap, one done cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = WALK;
      WALK:    if (rd_step && (remain_q == L'(1))) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Walk datapath: latch region on start (head is read pre-write), step the tap on rd_step
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      lat_lo_q <= '0;
      lat_hi_q <= '0;
      addr_q   <= '0;
      remain_q <= '0;
    end else if (start_acc) begin
      lat_lo_q <= lo_q[rd_ch];
      lat_hi_q <= hi_q[rd_ch];
      addr_q   <= rd_nxt;
      remain_q <= rd_len;
    end else if ((state_q == WALK) && rd_step) begin
      addr_q   <= rd_nxt;
      remain_q <= remain_q - 1'b1;
    end
  end

  assign rd_addr  = addr_q;
  assign rd_valid = (state_q == WALK);
  assign rd_last  = (state_q == WALK) && (remain_q == L'(1));
  assign rd_done  = (state_q == FIN);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_rbuf_addr_gen_mc.sv
// Bench for rbuf_addr_gen_mc: directed cases then random traffic against a queue-based model.
// Inputs driven 1 ns after the rising edge, outputs sampled 2 ns after it.
// Error-check cases are compiled only when RBUF_ERR_CHECK_EN is defined.
module tb_rbuf_addr_gen_mc;

  localparam int A   = 12;
  localparam int L   = 10;
  localparam int NCH = 4;
  localparam int CHW = 2;
`ifdef RBUF_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           clr_n;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [A-1:0]   cfg_lo, cfg_hi;
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [A-1:0]   wr_addr;
  logic           rd_start;
  logic [CHW-1:0] rd_ch;
  logic [L-1:0]   rd_len;
  logic           rd_step;
  logic [A-1:0]   rd_addr;
  logic           rd_valid, rd_last, rd_done, busy, err;

  always #5 clk = ~clk;

  rbuf_addr_gen_mc #(
    .DATA_ADDRESS_WIDTH (A),
    .DATA_OFFSET_WIDTH  (L),
    .CHANNELS           (NCH),
    .CH_WIDTH           (CHW)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_lo   (cfg_lo),
    .cfg_hi   (cfg_hi),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_addr  (wr_addr),
    .rd_start (rd_start),
    .rd_ch    (rd_ch),
    .rd_len   (rd_len),
    .rd_step  (rd_step),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_last  (rd_last),
    .rd_done  (rd_done),
    .busy     (busy),
    .err      (err)
  );

  typedef struct {
    bit cfg_we;   int cfg_ch; int cfg_lo; int cfg_hi;
    bit wr_en;    int wr_ch;
    bit rd_start; int rd_ch;  int rd_len; bit rd_step;
  } stim_t;

  // Reference model: region table plus the list of tap addresses still to be presented
  int m_lo [NCH];
  int m_hi [NCH];
  int m_head [NCH];
  int q [$];
  bit m_fin;
  int m_ch;
  bit m_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] obs_wr_addr, obs_rd_addr;
  logic        obs_rd_last, obs_rd_done, obs_busy, obs_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic stim_t nop(input int ch);
    stim_t s;
    s = '{default: 0};
    s.wr_ch = ch;
    return s;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_lo[c] = 0; m_hi[c] = 0; m_head[c] = 0;
    end
    q.delete();
    m_fin = 1'b0;
    m_ch  = 0;
    m_err = 1'b0;
  endtask

  task automatic drive(input stim_t s);
    cfg_we   = s.cfg_we;
    cfg_ch   = s.cfg_ch[CHW-1:0];
    cfg_lo   = s.cfg_lo[A-1:0];
    cfg_hi   = s.cfg_hi[A-1:0];
    wr_en    = s.wr_en;
    wr_ch    = s.wr_ch[CHW-1:0];
    rd_start = s.rd_start;
    rd_ch    = s.rd_ch[CHW-1:0];
    rd_len   = s.rd_len[L-1:0];
    rd_step  = s.rd_step;
  endtask

  // Advance the model by one clock edge with the given inputs
  task automatic model_step(input stim_t s);
    bit walking, idle, nerr, bad, cfg_done;
    int size, len, idx, wch;
    walking  = (q.size() != 0);
    idle     = !walking && !m_fin;
    wch      = m_ch;
    nerr     = 1'b0;
    cfg_done = 1'b0;
    if (m_fin) m_fin = 1'b0;
    else if (walking && s.rd_step) begin
      void'(q.pop_front());
      if (q.size() == 0) m_fin = 1'b1;
    end
    if (s.rd_start) begin
      if (!idle) nerr = ERR_EN;
      else begin
        size = m_hi[s.rd_ch] - m_lo[s.rd_ch] + 1;
        len  = (s.rd_len == 0) ? (1 << L) : s.rd_len;
        bad  = ERR_EN && ((s.rd_len == 0) || (len > size));
        if (bad) nerr = 1'b1;
        else begin
          idx = m_head[s.rd_ch] - m_lo[s.rd_ch];
          q.delete();
          for (int i = 0; i < len; i++)
            q.push_back(m_lo[s.rd_ch] + ((((idx - 1 - i) % size) + size) % size));
          m_ch = s.rd_ch;
        end
      end
    end
    if (s.cfg_we) begin
      bad = ERR_EN && ((s.cfg_lo > s.cfg_hi) || (!idle && (s.cfg_ch == wch)));
      if (bad) nerr = 1'b1;
      else begin
        m_lo[s.cfg_ch]   = s.cfg_lo;
        m_hi[s.cfg_ch]   = s.cfg_hi;
        m_head[s.cfg_ch] = s.cfg_lo;
        cfg_done = 1'b1;
      end
    end
    if (s.wr_en && !(cfg_done && (s.cfg_ch == s.wr_ch))) begin
      size = m_hi[s.wr_ch] - m_lo[s.wr_ch] + 1;
      m_head[s.wr_ch] = m_lo[s.wr_ch] + ((m_head[s.wr_ch] - m_lo[s.wr_ch] + 1) % size);
    end
    m_err = nerr;
  endtask

  // One clock: drive, sample and compare against the model, then advance
  task automatic cyc(input stim_t s);
    drive(s);
    #1;
    obs_wr_addr = 32'(wr_addr);
    obs_rd_addr = 32'(rd_addr);
    obs_rd_last = rd_last;
    obs_rd_done = rd_done;
    obs_busy    = busy;
    obs_err     = err;
    check("wr_addr",  32'(wr_addr), m_head[s.wr_ch]);
    check("busy",     32'(busy),    32'((q.size() != 0) || m_fin));
    check("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    check("rd_done",  32'(rd_done), 32'(m_fin));
    check("rd_last",  32'(rd_last), 32'(q.size() == 1));
    check("err",      32'(err),     32'(m_err));
    if (q.size() != 0) check("rd_addr", 32'(rd_addr), q[0]);
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  stim_t s;
  int    wexp [5];
  int    aexp [6];
  int    bexp [6];
  int    lo_r;

  initial begin
    clr_n = 1'b0;
    drive(nop(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",    32'(busy), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    // Write wrap on ch0
    s = nop(0); s.cfg_we = 1; s.cfg_ch = 0; s.cfg_lo = 'h100; s.cfg_hi = 'h103;
    cyc(s);
    wexp = '{'h100, 'h101, 'h102, 'h103, 'h100};
    for (int i = 0; i < 5; i++) begin
      s = nop(0); s.wr_en = 1;
      cyc(s);
      check("wrap_wr_addr", obs_wr_addr, wexp[i]);
    end

    // Backward walk with wrap on ch1
    s = nop(1); s.cfg_we = 1; s.cfg_ch = 1; s.cfg_lo = 'h200; s.cfg_hi = 'h207;
    cyc(s);
    repeat (2) begin s = nop(1); s.wr_en = 1; cyc(s); end
    s = nop(1); s.rd_start = 1; s.rd_ch = 1; s.rd_len = 4;
    cyc(s);
    aexp[0:3] = '{'h201, 'h200, 'h207, 'h206};
    for (int i = 0; i < 4; i++) begin
      s = nop(1); s.rd_step = 1;
      cyc(s);
      check("walk_rd_addr", obs_rd_addr, aexp[i]);
      check("walk_rd_last", 32'(obs_rd_last), 32'(i == 3));
    end
    cyc(nop(1));
    check("walk_rd_done", 32'(obs_rd_done), 1);
    cyc(nop(1));
    check("walk_busy_after", 32'(obs_busy), 0);

    // Same-cycle write and start on ch0: walk excludes the sample being written
    s = nop(0); s.wr_en = 1;
    cyc(s);
    s = nop(0); s.wr_en = 1; s.rd_start = 1; s.rd_ch = 0; s.rd_len = 2;
    cyc(s);
    check("same_wr_addr", obs_wr_addr, 'h102);
    s = nop(0); s.rd_step = 1;
    cyc(s);
    check("same_rd_addr", obs_rd_addr, 'h101);
    check("same_head", obs_wr_addr, 'h103);
    s = nop(0); s.rd_step = 1;
    cyc(s);
    check("same_rd_addr2", obs_rd_addr, 'h100);
    cyc(nop(0));
    cyc(nop(0));

    // Channel isolation: ch2 writes interleaved with a ch3 walk
    s = nop(3); s.cfg_we = 1; s.cfg_ch = 3; s.cfg_lo = 'h300; s.cfg_hi = 'h30F;
    cyc(s);
    repeat (5) begin s = nop(3); s.wr_en = 1; cyc(s); end
    s = nop(2); s.cfg_we = 1; s.cfg_ch = 2; s.cfg_lo = 'h400; s.cfg_hi = 'h403;
    cyc(s);
    s = nop(2); s.rd_start = 1; s.rd_ch = 3; s.rd_len = 6;
    cyc(s);
    aexp = '{'h304, 'h303, 'h302, 'h301, 'h300, 'h30F};
    bexp = '{'h400, 'h401, 'h402, 'h403, 'h400, 'h401};
    for (int i = 0; i < 6; i++) begin
      s = nop(2); s.rd_step = 1; s.wr_en = 1;
      cyc(s);
      check("iso_rd_addr", obs_rd_addr, aexp[i]);
      check("iso_wr_addr", obs_wr_addr, bexp[i]);
    end
    cyc(nop(2));
    check("iso_head_final", obs_wr_addr, 'h402);
    cyc(nop(2));

`ifdef RBUF_ERR_CHECK_EN
    // Rejected commands: one err pulse each, no state change
    s = nop(1); s.rd_start = 1; s.rd_ch = 1; s.rd_len = 0;
    cyc(s);
    cyc(nop(1));
    check("err_len0", 32'(obs_err), 1);
    check("err_len0_busy", 32'(obs_busy), 0);
    s = nop(1); s.rd_start = 1; s.rd_ch = 1; s.rd_len = 9;
    cyc(s);
    cyc(nop(1));
    check("err_len9", 32'(obs_err), 1);
    check("err_len9_busy", 32'(obs_busy), 0);
    s = nop(1); s.rd_start = 1; s.rd_ch = 1; s.rd_len = 3;
    cyc(s);
    s = nop(1); s.rd_start = 1; s.rd_ch = 2; s.rd_len = 2;
    cyc(s);
    check("err_busy_first_tap", obs_rd_addr, 'h201);
    s = nop(1); s.cfg_we = 1; s.cfg_ch = 1; s.cfg_lo = 'h500; s.cfg_hi = 'h505;
    cyc(s);
    check("err_start_busy", 32'(obs_err), 1);
    s = nop(1); s.rd_step = 1;
    cyc(s);
    check("err_cfg_walked", 32'(obs_err), 1);
    check("err_walk_addr", obs_rd_addr, 'h201);
    repeat (4) begin s = nop(1); s.rd_step = 1; cyc(s); end
    check("err_cfg_kept_head", obs_wr_addr, 'h202);
    s = nop(2); s.cfg_we = 1; s.cfg_ch = 2; s.cfg_lo = 'h410; s.cfg_hi = 'h40F;
    cyc(s);
    cyc(nop(2));
    check("err_lo_gt_hi", 32'(obs_err), 1);
    check("err_lo_gt_hi_head", obs_wr_addr, 'h402);
`endif

    // Asynchronous reset in the middle of a walk
    s = nop(1); s.rd_start = 1; s.rd_ch = 1; s.rd_len = 4;
    cyc(s);
    s = nop(1); s.rd_step = 1;
    cyc(s);
    #3;
    clr_n = 1'b0;
    drive(nop(0));
    #1;
    check("arst_busy",     32'(busy), 0);
    check("arst_rd_valid", 32'(rd_valid), 0);
    check("arst_rd_addr",  32'(rd_addr), 0);
    check("arst_rd_done",  32'(rd_done), 0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    model_reset();
    for (int c = 0; c < NCH; c++) begin
      wr_ch = c[CHW-1:0];
      #1;
      check("arst_wr_addr", 32'(wr_addr), 0);
    end
    @(posedge clk);
    #1;

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      s = nop($urandom_range(0, NCH-1));
      if ($urandom_range(0, 19) == 0) begin
        s.cfg_we = 1;
        s.cfg_ch = $urandom_range(0, NCH-1);
        lo_r     = $urandom_range(1, 'hFF0);
        s.cfg_lo = lo_r;
        s.cfg_hi = lo_r + $urandom_range(0, 15);
        if (ERR_EN && ($urandom_range(0, 3) == 0)) s.cfg_hi = lo_r - 1;
      end
      s.wr_en    = $urandom_range(0, 1);
      s.rd_start = ($urandom_range(0, 7) == 0);
      s.rd_ch    = $urandom_range(0, NCH-1);
      s.rd_len   = $urandom_range(ERR_EN ? 0 : 1, 20);
      s.rd_step  = ($urandom_range(0, 9) < 6);
      cyc(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
